// File: rtl/lw_sha_pkg.sv
// Shared helpers for the lightweight SHA core: rotated-word state encoding,
// FSM state type for the digest output stage and the digest-length clamp.
package lw_sha_pkg;

    localparam int unsigned DIGEST_WORDS_MAX = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_CLEAR  = 2'd2
    } digest_state_e;

    // Width-generic rotates: 32-bit words live in the low half of x.
    function automatic logic [63:0] rotl_w(input logic [63:0] x, input logic [5:0] r,
                                           input logic is64);
        logic [31:0] lo;
        logic [63:0] res;
        lo = x[31:0];
        if (is64) begin
            res = (x << r) | (x >> (7'd64 - {1'b0, r}));
        end else begin
            res = {32'h0000_0000, (lo << r[4:0]) | (lo >> (6'd32 - {1'b0, r[4:0]}))};
        end
        return res;
    endfunction

    function automatic logic [63:0] rotr_w(input logic [63:0] x, input logic [5:0] r,
                                           input logic is64);
        logic [31:0] lo;
        logic [63:0] res;
        lo = x[31:0];
        if (is64) begin
            res = (x >> r) | (x << (7'd64 - {1'b0, r}));
        end else begin
            res = {32'h0000_0000, (lo >> r[4:0]) | (lo << (6'd32 - {1'b0, r[4:0]}))};
        end
        return res;
    endfunction

    // Encoded word stores p = rotr(x, r); the reader undoes it with rotl.
    function automatic logic [63:0] encode_word(input logic [63:0] x, input logic [5:0] r,
                                                input logic is64);
        return rotr_w(x, r, is64);
    endfunction

    function automatic logic [63:0] read_word(input logic [63:0] p, input logic [5:0] r,
                                              input logic is64);
        return rotl_w(p, r, is64);
    endfunction

    function automatic logic [3:0] clamp_words(input logic [3:0] n);
        logic [3:0] res;
        if ((n == 4'd0) || (n > 4'(DIGEST_WORDS_MAX))) begin
            res = 4'(DIGEST_WORDS_MAX);
        end else begin
            res = n;
        end
        return res;
    endfunction

endpackage

// File: rtl/lw_sha_digest_out.sv
// Digest output stage: captures the encoded working state and previous hash,
// streams decode(state)+h_prev one word per beat, then zeroizes everything.
module lw_sha_digest_out
    import lw_sha_pkg::*;
#(
    parameter  int WORD_SIZE = 32,
    localparam int RW        = $clog2(WORD_SIZE)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [WORD_SIZE+RW-1:0] state_i   [8],
    input  logic [WORD_SIZE-1:0]    h_prev_i  [8],
    input  logic [3:0]              num_words,
    input  logic                    abort,
    output logic [WORD_SIZE-1:0]    out_word,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    busy,
    output logic                    done
);

    localparam logic IS64 = (WORD_SIZE == 64);

    digest_state_e           state_r;
    digest_state_e           state_nxt_s;
    logic [WORD_SIZE+RW-1:0] st_r [8];
    logic [WORD_SIZE-1:0]    hp_r [8];
    logic [2:0]              idx_r;
    logic [2:0]              idx_nxt_s;
    logic [2:0]              last_r;
    logic [3:0]              nw_clamp_s;
    logic                    capture_s;
    logic                    load_s;
    logic                    fire_s;
    logic [WORD_SIZE+RW-1:0] sel_st_s;
    logic [WORD_SIZE-1:0]    sel_hp_s;
    logic [63:0]             p64_s;
    logic [5:0]              r6_s;
    logic [WORD_SIZE-1:0]    word_s;
    logic [WORD_SIZE-1:0]    out_word_r;
    logic                    out_valid_r;
    logic                    busy_r;
    logic                    done_r;

    assign fire_s     = out_valid_r & out_ready;
    assign nw_clamp_s = clamp_words(num_words);

    // Next-state, beat index and word-load decisions.
    always_comb begin
        state_nxt_s = state_r;
        idx_nxt_s   = idx_r;
        capture_s   = 1'b0;
        load_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s = ST_STREAM;
                    idx_nxt_s   = 3'd0;
                    capture_s   = 1'b1;
                    load_s      = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_STREAM: begin
                if (fire_s) begin
                    idx_nxt_s = idx_r + 3'd1;
                    if ((idx_r == last_r) || abort) begin
                        state_nxt_s = ST_CLEAR;
                    end else begin
                        load_s = 1'b1;
                    end
                end else if (abort) begin
                    state_nxt_s = ST_CLEAR;
                end else begin
                    state_nxt_s = ST_STREAM;
                end
            end
            ST_CLEAR: begin
                state_nxt_s = ST_IDLE;
                idx_nxt_s   = 3'd0;
            end
            default: begin
                state_nxt_s = ST_IDLE;
                idx_nxt_s   = 3'd0;
            end
        endcase
    end

    // Word select, decode and feed-forward add; word 0 comes straight from the inputs at capture.
    always_comb begin
        sel_st_s = '0;
        sel_hp_s = '0;
        p64_s    = '0;
        r6_s     = '0;
        if (capture_s) begin
            sel_st_s = state_i[7];
            sel_hp_s = h_prev_i[7];
        end else begin
            sel_st_s = st_r[3'd7 - idx_nxt_s];
            sel_hp_s = hp_r[3'd7 - idx_nxt_s];
        end
        p64_s[WORD_SIZE-1:0] = sel_st_s[WORD_SIZE-1:0];
        r6_s[RW-1:0]         = sel_st_s[WORD_SIZE+RW-1:WORD_SIZE];
        word_s = WORD_SIZE'(read_word(p64_s, r6_s, IS64)) + sel_hp_s;
    end

    // FSM state, beat index and registered handshake/status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            idx_r       <= 3'd0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            idx_r       <= idx_nxt_s;
            out_valid_r <= (state_nxt_s == ST_STREAM);
            busy_r      <= (state_nxt_s != ST_IDLE);
            done_r      <= (state_nxt_s == ST_CLEAR);
        end
    end

    // Secret capture registers: loaded on start, wiped on the way out of CLEAR.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                st_r[i] <= '0;
                hp_r[i] <= '0;
            end
            last_r <= 3'd0;
        end else if (capture_s) begin
            for (int i = 0; i < 8; i++) begin
                st_r[i] <= state_i[i];
                hp_r[i] <= h_prev_i[i];
            end
            last_r <= 3'(nw_clamp_s - 4'd1);
        end else if (state_r == ST_CLEAR) begin
            for (int i = 0; i < 8; i++) begin
                st_r[i] <= '0;
                hp_r[i] <= '0;
            end
            last_r <= 3'd0;
        end else begin
            last_r <= last_r;
        end
    end

    // Output word register: held under backpressure, zero whenever not streaming.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_word_r <= '0;
        end else if (state_nxt_s != ST_STREAM) begin
            out_word_r <= '0;
        end else if (load_s) begin
            out_word_r <= word_s;
        end else begin
            out_word_r <= out_word_r;
        end
    end

    assign out_word  = out_word_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign done      = done_r;

endmodule

// File: tb/tb_lw_sha_digest_out.sv
// Directed bench for lw_sha_digest_out (WORD_SIZE=32): decode sanity, SHA-256 "abc",
// wrap-around, backpressure, truncation/clamp, abort and mid-stream reset.
module tb_lw_sha_digest_out;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [36:0] state_i  [8];
    logic [31:0] h_prev_i [8];
    logic [3:0]  num_words;
    logic        abort;
    logic [31:0] out_word;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        done;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] dig  [8] = '{32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
                              32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad};
    logic [31:0] iv   [8] = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                              32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    int          rots [8] = '{0, 7, 13, 31, 4, 19, 1, 26};
    logic [31:0] exp_w [8];

    lw_sha_digest_out #(.WORD_SIZE(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .state_i   (state_i),
        .h_prev_i  (h_prev_i),
        .num_words (num_words),
        .abort     (abort),
        .out_word  (out_word),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] tb_rotr(input logic [31:0] x, input int r);
        logic [63:0] t;
        t = {x, x} >> r;
        return t[31:0];
    endfunction

    task automatic clear_inputs();
        for (int i = 0; i < 8; i++) begin
            state_i[i]  = '0;
            h_prev_i[i] = '0;
            exp_w[i]    = '0;
        end
    endtask

    // Final working state = digest - IV, encoded with a per-word rotation.
    task automatic load_abc();
        logic [31:0] x;
        for (int i = 0; i < 8; i++) begin
            x               = dig[i] - iv[i];
            state_i[7 - i]  = {5'(rots[i]), tb_rotr(x, rots[i])};
            h_prev_i[7 - i] = iv[i];
            exp_w[i]        = dig[i];
        end
    endtask

    task automatic pulse_start(input logic [3:0] nw);
        num_words = nw;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    // Accept beats until done; optionally stall 3 cycles on one beat while poking start/inputs.
    task automatic collect(input int stall_beat, output int beats, output int dcyc);
        int   stalls;
        logic seen;
        beats  = 0;
        dcyc   = -1;
        stalls = 0;
        seen   = 1'b0;
        for (int cyc = 0; cyc < 40 && !seen; cyc++) begin
            if (done) begin
                seen = 1'b1;
                dcyc = cyc;
                check_eq("done_excl_valid", out_valid, 1'b0);
            end else begin
                if (out_valid) begin
                    if (beats < 8) check_eq("word", out_word, exp_w[beats]);
                    else check_eq("excess_beat", 64'(beats), 64'd7);
                    if (beats == stall_beat && stalls < 3) begin
                        out_ready  = 1'b0;
                        start      = 1'b1;
                        state_i[0] = '1;
                        stalls++;
                    end else begin
                        out_ready = 1'b1;
                        start     = 1'b0;
                        beats++;
                    end
                end
                tick();
            end
        end
        out_ready = 1'b1;
        start     = 1'b0;
        check_eq("done_seen", seen, 1'b1);
        tick();
    endtask

    initial begin
        int beats;
        int dcyc;
        int done_cnt;
        rst_n     = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        out_ready = 1'b1;
        num_words = 4'd0;
        clear_inputs();
        tick();
        tick();
        check_eq("rst_word", out_word, 32'h0);
        check_eq("rst_valid", out_valid, 1'b0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_done", done, 1'b0);
        rst_n = 1'b1;
        tick();

        // Decode sanity: rotl(76a09e66, 4) = 6a09e667.
        state_i[7] = {5'd4, 32'h76a09e66};
        pulse_start(4'd1);
        check_eq("dec_valid", out_valid, 1'b1);
        check_eq("dec_word", out_word, 32'h6a09e667);
        check_eq("dec_busy", busy, 1'b1);
        tick();
        check_eq("dec_done", done, 1'b1);
        check_eq("dec_valid_off", out_valid, 1'b0);
        check_eq("dec_word_zero", out_word, 32'h0);
        tick();
        check_eq("dec_done_off", done, 1'b0);
        check_eq("dec_idle", busy, 1'b0);

        // SHA-256 "abc", full rate, then a back-to-back run with backpressure.
        load_abc();
        pulse_start(4'd8);
        collect(-1, beats, dcyc);
        check_eq("abc_beats", 64'(beats), 64'd8);
        check_eq("abc_done_cycle", 64'(dcyc), 64'd8);
        check_eq("abc_idle", busy, 1'b0);
        pulse_start(4'd8);
        collect(2, beats, dcyc);
        check_eq("bp_beats", 64'(beats), 64'd8);

        // Wrap-around: decode 2 plus ffffffff.
        clear_inputs();
        state_i[7]  = {5'd1, 32'h00000001};
        h_prev_i[7] = 32'hffffffff;
        exp_w[0]    = 32'h00000001;
        pulse_start(4'd1);
        collect(-1, beats, dcyc);
        check_eq("wrap_beats", 64'(beats), 64'd1);

        // Truncation and clamp.
        load_abc();
        pulse_start(4'd7);
        collect(-1, beats, dcyc);
        check_eq("trunc7_beats", 64'(beats), 64'd7);
        pulse_start(4'd0);
        collect(-1, beats, dcyc);
        check_eq("clamp0_beats", 64'(beats), 64'd8);
        pulse_start(4'd12);
        collect(-1, beats, dcyc);
        check_eq("clamp12_beats", 64'(beats), 64'd8);

        // Abort coinciding with the third beat.
        pulse_start(4'd8);
        tick();
        tick();
        check_eq("abort_word2", out_word, exp_w[2]);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_eq("abort_done", done, 1'b1);
        check_eq("abort_valid", out_valid, 1'b0);
        check_eq("abort_word", out_word, 32'h0);
        tick();
        check_eq("abort_st_zero", dut.st_r[7], 37'h0);
        check_eq("abort_hp_zero", dut.hp_r[7], 32'h0);
        check_eq("abort_idle", busy, 1'b0);

        // Reset mid-stream: immediate zero outputs, no done pulse.
        pulse_start(4'd8);
        tick();
        rst_n = 1'b0;
        #1;
        check_eq("rst_mid_valid", out_valid, 1'b0);
        check_eq("rst_mid_word", out_word, 32'h0);
        check_eq("rst_mid_busy", busy, 1'b0);
        tick();
        rst_n    = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) done_cnt++;
            tick();
        end
        check_eq("rst_mid_no_done", 64'(done_cnt), 64'd0);
        check_eq("rst_mid_idle", busy, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/lw_sha_digest_out.md
# lw_sha_digest_out

Output stage of the lightweight SHA core; the reader counterpart of the round datapath's rotated-word state encoding. On completion of the last round of a block, it captures the eight encoded working-state words and the plain previous hash words. It then decodes each state word, applies the SHA feed-forward addition, and streams the digest one word per beat over a valid/ready interface. All captured secret material is zeroized after the final beat or on abort.

## Interface
Parameters:
- WORD_SIZE, 32, digest word width; legal values 32 (SHA-224/256) or 64 (SHA-384/512).
- RW, $clog2(WORD_SIZE), rotation-field width; derived, not overridden.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  capture request; honoured only in IDLE.
- state_i  input  [WORD_SIZE+RW-1:0] x8  encoded working state; index 7 = a … 0 = h.
- h_prev_i  input  [WORD_SIZE-1:0] x8  plain previous hash; index 7 = H0 … 0 = H7.
- num_words  input  4  words to emit; 1..8 used as is, 0 or >8 treated as 8.
- abort  input  1  synchronous abort; forces zeroization.
- out_word  output  [WORD_SIZE-1:0]  digest word.
- out_valid  output  1  out_word valid.
- out_ready  input  1  sink accepts beat.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse at the end of zeroization.

## Operation
- Encoding: encoded word = {r[RW-1:0], p[WORD_SIZE-1:0]} with p = rotr(x, r). Decode x = rotl(p, r). r = 0 is legal and means no rotation.
- Digest word i = decode(state_i[7-i]) + h_prev_i[7-i], mod 2^WORD_SIZE; carry discarded.
- FSM states:
  - IDLE: start=1 latches state_i, h_prev_i and clamped num_words, clears idx to 0, and moves to STREAM.
  - STREAM: out_valid=1. A beat is accepted when out_valid && out_ready; each beat increments idx. The beat with idx == num_words-1 moves to CLEAR.
  - CLEAR: zeroizes all captured registers, idx and out_word; done=1; next state IDLE.
- abort=1 in STREAM moves to CLEAR the next cycle. If abort coincides with a handshake, the beat counts as delivered, but no further beats are issued. abort in IDLE or CLEAR has no effect.
- start outside IDLE is ignored; inputs may change freely after capture.
- out_word is driven registered, or from registered inputs through the decode/add path, and is 0 whenever out_valid=0.
- Reset: state IDLE; out_word=0, out_valid=0, busy=0, done=0; all capture registers 0. Reset mid-stream discards the transfer without a done pulse.

## Timing
- start sampled at edge N → out_valid=1 with word 0 from cycle N+1.
- With out_ready held high, one word per cycle: 8 words occupy N+1..N+8, CLEAR/done at N+9, IDLE at N+10. Back-to-back start is accepted at N+10.
- Backpressure: while out_valid && !out_ready, out_word is held stable.
- done is never asserted in the same cycle as out_valid.
- Combinational depth: one barrel rotate plus one WORD_SIZE adder. Inputs are not feedthrough; there is no output-to-input combinational path.

## Structure
- The decode function read_word (rotl by the embedded r) and the rotate helpers live in lw_sha_pkg, shared with the round datapath; the encode/decode pair is defined there once.
- Add a num_words clamp constant DIGEST_WORDS_MAX = 8 to lw_sha_pkg.
- Single module. The word mux, decode and add form one combinational path inside the module; no sub-module is needed.

## Test plan
- Decode sanity: state_i[7] = {5'd4, 32'h76a09e66}, h_prev all 0, num_words=1, out_ready=1 → one beat 32'h6a09e667 at N+1, done at N+2.
- Full SHA-256 "abc": encoded final state with random r per word plus the standard IV → 8 beats ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad, then done.
- Wrap-around: decode = 32'h00000002, h_prev = 32'hffffffff → out_word 32'h00000001.
- Backpressure: out_ready low for 3 cycles on word 2 → out_word stable, no skipped or duplicated word, total beats = num_words. start issued during STREAM is ignored.
- Truncation and clamp: num_words=7 → 7 beats, then done. num_words=0 → 8 beats.
- Abort/reset: abort after beat 3 → CLEAR next cycle, done pulse, capture registers read 0. A second run with rst_n low mid-stream → outputs 0 immediately and no done pulse.
